// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: core instruction/data request streams, halt handshake and the shared RAM port.
// The arbiter takes the slave side; the core and RAM model take the master side.
interface mem_req_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        halt;
    logic        halted;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
        output iload, iwait, dload, dwait, halted, ramREN, ramWEN, ramaddr, ramstore
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
        input  iload, iwait, dload, dwait, halted, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one RAM port between instruction and data streams, data-first with
// a starvation bound for fetches, and drains data traffic on halt before reporting halted.
module mem_req_arbiter #(
    parameter int DSTARVE_MAX = 4
) (
    input logic CLK,
    input logic nRST,
    mem_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;
    state_t     state, next_state;
    logic [3:0] dcount;
    logic       halt_pend, halted_q;
    logic       access, dreq, force_i, halted_now, iacc, dacc;

    assign access     = bus.ramstate == 2'd2;
    assign dreq       = bus.dREN | bus.dWEN;
    assign force_i    = bus.iREN & !halt_pend & (dcount == 4'(DSTARVE_MAX));
    // halted is visible in the very IDLE cycle that completes the drain, then held by halted_q
    assign halted_now = halted_q | (halt_pend & state == IDLE & !dreq);

    always_comb
        next_state = state == IDLE ? (halted_now ? IDLE :
                                      dreq && !force_i ? DSERV :
                                      bus.iREN && !halt_pend ? ISERV : IDLE)
                                   : (access ? IDLE : state);

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state     <= IDLE;
            dcount    <= 4'd0;
            halt_pend <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (bus.halt) halt_pend <= 1'b1;
            if (halted_now) halted_q <= 1'b1;
            if (state == IDLE)
                dcount <= (next_state == ISERV || !bus.iREN) ? 4'd0 :
                          (next_state == DSERV && dcount != 4'(DSTARVE_MAX)) ? dcount + 4'd1 : dcount;
        end

    assign iacc         = state == ISERV && access;
    assign dacc         = state == DSERV && access;
    assign bus.ramREN   = state == ISERV || (state == DSERV && !bus.dWEN);
    assign bus.ramWEN   = state == DSERV && bus.dWEN;
    assign bus.ramaddr  = state == ISERV ? bus.iaddr : state == DSERV ? bus.daddr : 32'd0;
    assign bus.ramstore = bus.ramWEN ? bus.dstore : 32'd0;
    assign bus.iwait    = !iacc;
    assign bus.dwait    = !dacc;
    assign bus.iload    = iacc ? bus.ramload : 32'd0;
    assign bus.dload    = dacc ? bus.ramload : 32'd0;
    assign bus.halted   = halted_now;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level owner/streak model of the arbiter.
module tb_mem_req_arbiter;
    localparam int DMAX = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    mem_req_arbiter_if bus();
    mem_req_arbiter #(.DSTARVE_MAX(DMAX)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    // reference model: who owns the RAM (0 none, 1 data, 2 instruction), consecutive data grants
    // while a fetch waits, halt seen, drain finished
    int m_own, m_streak;
    bit m_hp, m_hd;

    task automatic clear_inputs;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
        bus.halt = 0; bus.ramload = 0; bus.ramstate = FREE;
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        clear_inputs;
        nRST = 0;
        step;
        step;
        nRST = 1;
        m_own = 0; m_streak = 0; m_hp = 0; m_hd = 0;
    endtask

    task automatic test_reset;
        clear_inputs;
        nRST = 0;
        #3;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.halted} !== 5'b00110 ||
            bus.ramaddr !== 0 || bus.ramstore !== 0 || bus.iload !== 0 || bus.dload !== 0) begin
            errors++;
            $display("FAIL reset_hold: ren/wen/iwait/dwait/halted=%b addr=%h store=%h iload=%h dload=%h, expected 00110 and zeros",
                     {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.halted}, bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
        end
        step;
        nRST = 1;
        for (int c = 0; c < 3; c++) begin
            step;
            checks++;
            if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.halted} !== 5'b00110 ||
                bus.ramaddr !== 0 || bus.ramstore !== 0) begin
                errors++;
                $display("FAIL reset_release c%0d: ren/wen/iwait/dwait/halted=%b addr=%h, expected 00110 addr=0",
                         c, {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.halted}, bus.ramaddr);
            end
        end
    endtask

    task automatic test_ifetch;
        do_reset;
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY; bus.ramload = 32'h2402000A;
        #1;
        checks++;
        if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL ifetch_arb: ramREN=%b iwait=%b, expected 0 1", bus.ramREN, bus.iwait);
        end
        step;
        for (int c = 1; c <= 3; c++) begin
            bus.ramstate = (c == 3) ? ACCESS : BUSY;
            #1;
            checks++;
            if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h40 || bus.dwait !== 1'b1 ||
                bus.iwait !== (c != 3) || bus.iload !== ((c == 3) ? 32'h2402000A : 32'h0)) begin
                errors++;
                $display("FAIL ifetch_serv c%0d: ren=%b wen=%b addr=%h iwait=%b iload=%h dwait=%b, expected ren=1 addr=40 iwait=%b",
                         c, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.iload, bus.dwait, c != 3);
            end
            step;
        end
        bus.iREN = 0; bus.ramstate = FREE;
        #1;
        checks++;
        if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL ifetch_done: ramREN=%b iwait=%b, expected 0 1", bus.ramREN, bus.iwait);
        end
    endtask

    task automatic test_priority;
        do_reset;
        bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h100;
        bus.ramstate = ACCESS; bus.ramload = 32'h13572468;
        #1;
        step;
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.dwait !== 1'b0 || bus.dload !== 32'h13572468 ||
            bus.iwait !== 1'b1 || bus.iload !== 0) begin
            errors++;
            $display("FAIL prio_data: ren=%b addr=%h dwait=%b dload=%h iwait=%b, expected 1 00000100 0 13572468 1",
                     bus.ramREN, bus.ramaddr, bus.dwait, bus.dload, bus.iwait);
        end
        step;
        bus.dREN = 0;
        #1;
        checks++;
        if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
            errors++;
            $display("FAIL prio_gap: ren=%b iwait=%b dwait=%b, expected 0 1 1", bus.ramREN, bus.iwait, bus.dwait);
        end
        step;
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44 || bus.iwait !== 1'b0 || bus.iload !== 32'h13572468 ||
            bus.dwait !== 1'b1) begin
            errors++;
            $display("FAIL prio_inst: ren=%b addr=%h iwait=%b iload=%h dwait=%b, expected 1 00000044 0 13572468 1",
                     bus.ramREN, bus.ramaddr, bus.iwait, bus.iload, bus.dwait);
        end
        step;
        clear_inputs;
    endtask

    task automatic test_starvation;
        int k;
        byte got, exp;
        do_reset;
        bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = ACCESS;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (bus.ramREN === 1'b1) begin
                got = bus.ramaddr == 32'h300 ? "D" : bus.ramaddr == 32'h80 ? "I" : "?";
                exp = (k % 5 == 4) ? "I" : "D";
                checks++;
                if (got !== exp || bus.iwait !== (exp == "D") || bus.dwait !== (exp == "I")) begin
                    errors++;
                    $display("FAIL starve_grant%0d: got %c iwait=%b dwait=%b, expected %c", k, got, bus.iwait, bus.dwait, exp);
                end
                k++;
            end
            step;
        end
        checks++;
        if (k !== 15) begin
            errors++;
            $display("FAIL starve_count: %0d grants, expected 15", k);
        end
        clear_inputs;
    endtask

    task automatic test_write_error;
        do_reset;
        bus.dWEN = 1; bus.dREN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF; bus.ramstate = ERROR;
        #1;
        checks++;
        if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin
            errors++;
            $display("FAIL wr_arb: wen=%b ren=%b dwait=%b, expected 0 0 1", bus.ramWEN, bus.ramREN, bus.dwait);
        end
        step;
        for (int c = 1; c <= 3; c++) begin
            bus.ramstate = (c == 3) ? ACCESS : ERROR;
            #1;
            checks++;
            if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h200 || bus.ramstore !== 32'hDEADBEEF ||
                bus.dwait !== (c != 3) || bus.iwait !== 1'b1) begin
                errors++;
                $display("FAIL wr_serv c%0d: wen=%b ren=%b addr=%h store=%h dwait=%b, expected 1 0 00000200 deadbeef %b",
                         c, bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.dwait, c != 3);
            end
            step;
        end
        bus.dWEN = 0; bus.dREN = 0; bus.ramstate = FREE;
        #1;
        checks++;
        if (bus.ramWEN !== 1'b0 || bus.ramstore !== 0) begin
            errors++;
            $display("FAIL wr_done: wen=%b store=%h, expected 0 0", bus.ramWEN, bus.ramstore);
        end
    endtask

    task automatic test_halt;
        do_reset;
        bus.iREN = 1; bus.iaddr = 32'h48; bus.ramstate = BUSY; bus.ramload = 32'h8C220000;
        step;
        bus.halt = 1; bus.dWEN = 1; bus.daddr = 32'h204; bus.dstore = 32'hCAFEF00D;
        #1;
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h48 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_fetch1: ren=%b wen=%b addr=%h halted=%b, expected 1 0 00000048 0",
                     bus.ramREN, bus.ramWEN, bus.ramaddr, bus.halted);
        end
        step;
        bus.halt = 0; bus.ramstate = ACCESS;
        #1;
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h48 || bus.iwait !== 1'b0 || bus.iload !== 32'h8C220000) begin
            errors++;
            $display("FAIL halt_fetch2: ren=%b addr=%h iwait=%b iload=%h, expected 1 00000048 0 8c220000",
                     bus.ramREN, bus.ramaddr, bus.iwait, bus.iload);
        end
        step;
        checks++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_idle: ren=%b wen=%b halted=%b, expected 0 0 0", bus.ramREN, bus.ramWEN, bus.halted);
        end
        step;
        checks++;
        if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h204 || bus.ramstore !== 32'hCAFEF00D ||
            bus.dwait !== 1'b0) begin
            errors++;
            $display("FAIL halt_drain: wen=%b ren=%b addr=%h store=%h dwait=%b, expected 1 0 00000204 cafef00d 0",
                     bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.dwait);
        end
        step;
        bus.dWEN = 0;
        #1;
        checks++;
        if (bus.halted !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
            errors++;
            $display("FAIL halted_set: halted=%b ren=%b wen=%b, expected 1 0 0", bus.halted, bus.ramREN, bus.ramWEN);
        end
        for (int c = 0; c < 6; c++) begin
            step;
            if (c == 3) begin bus.dREN = 1; bus.daddr = 32'h20C; end
            #1;
            checks++;
            if (bus.halted !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
                errors++;
                $display("FAIL halted_sticky c%0d: halted=%b ren=%b wen=%b iwait=%b dwait=%b, expected 1 0 0 1 1",
                         c, bus.halted, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait);
            end
        end
        do_reset;
        bus.dWEN = 1; bus.daddr = 32'h208; bus.dstore = 32'h1234; bus.ramstate = BUSY;
        step;
        checks++;
        if (bus.ramWEN !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: wen=%b, expected 1", bus.ramWEN);
        end
        #2;
        nRST = 0;
        #1;
        checks++;
        if (bus.ramWEN !== 1'b0 || bus.ramaddr !== 0 || bus.ramstore !== 0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: wen=%b addr=%h store=%h halted=%b, expected 0 0 0 0",
                     bus.ramWEN, bus.ramaddr, bus.ramstore, bus.halted);
        end
        step;
        clear_inputs;
        nRST = 1;
    endtask

    task automatic test_random(input int n, input int halt_at);
        bit i_done, d_done, acc, e_halted;
        logic [65:0] e_ram;
        logic [66:0] e_core;
        do_reset;
        i_done = 0; d_done = 0;
        for (int c = 0; c < n; c++) begin
            if (i_done) bus.iREN = 0;
            if (d_done) begin bus.dREN = 0; bus.dWEN = 0; end
            if (!bus.iREN && $urandom_range(2) == 0) begin bus.iREN = 1; bus.iaddr = $urandom; end
            if (!bus.dREN && !bus.dWEN && $urandom_range(2) == 0) begin
                {bus.dWEN, bus.dREN} = 2'($urandom_range(1, 3));
                bus.daddr = $urandom;
                bus.dstore = $urandom;
            end
            bus.halt = (c == halt_at);
            bus.ramstate = 2'($urandom_range(3));
            bus.ramload = $urandom;
            #1;
            acc = bus.ramstate == ACCESS;
            e_halted = m_hd || (m_hp && m_own == 0 && !(bus.dREN || bus.dWEN));
            e_ram = {m_own == 2 || (m_own == 1 && !bus.dWEN), m_own == 1 && bus.dWEN,
                     m_own == 2 ? bus.iaddr : m_own == 1 ? bus.daddr : 32'h0,
                     (m_own == 1 && bus.dWEN) ? bus.dstore : 32'h0};
            e_core = {!(m_own == 2 && acc), !(m_own == 1 && acc),
                      (m_own == 2 && acc) ? bus.ramload : 32'h0, (m_own == 1 && acc) ? bus.ramload : 32'h0, e_halted};
            checks++;
            if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== e_ram) begin
                errors++;
                $display("FAIL rand_ram c%0d: got %h expected %h", c, {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}, e_ram);
            end
            checks++;
            if ({bus.iwait, bus.dwait, bus.iload, bus.dload, bus.halted} !== e_core) begin
                errors++;
                $display("FAIL rand_core c%0d: got %h expected %h", c, {bus.iwait, bus.dwait, bus.iload, bus.dload, bus.halted}, e_core);
            end
            checks++;
            if ((bus.iwait | bus.dwait) !== 1'b1) begin
                errors++;
                $display("FAIL rand_both_waits c%0d: iwait=%b dwait=%b, expected at least one 1", c, bus.iwait, bus.dwait);
            end
            i_done = !bus.iwait;
            d_done = !bus.dwait;
            @(posedge CLK);
            if (m_own == 0) begin
                if (!e_halted) begin
                    if ((bus.dREN || bus.dWEN) && !(bus.iREN && !m_hp && m_streak == DMAX)) begin
                        m_own = 1;
                        if (bus.iREN && m_streak < DMAX) m_streak++;
                    end else if (bus.iREN && !m_hp) begin
                        m_own = 2;
                        m_streak = 0;
                    end
                end
                if (!bus.iREN) m_streak = 0;
            end else if (acc) m_own = 0;
            m_hp |= bus.halt;
            m_hd |= e_halted;
            #1;
        end
        clear_inputs;
    endtask

    initial begin
        test_reset;
        test_ifetch;
        test_priority;
        test_starvation;
        test_write_error;
        test_halt;
        test_random(400, -1);
        test_random(300, 150);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
